// File: rtl/instr_mem_loader_pkg.sv
// imem_pkg: shared types and constants for the writable instruction memory.
//   imem_state_t   : loader FSM state (CLEAR, LOAD, RUN)
//   IMEM_DEPTH_DEF : default number of instruction bytes
//   IMEM_NOP       : value returned when the CPU must not see real code
package imem_pkg;

  typedef enum logic [1:0] {
    CLEAR = 2'd0,
    LOAD  = 2'd1,
    RUN   = 2'd2
  } imem_state_t;

  localparam int         IMEM_DEPTH_DEF = 32;
  localparam logic [7:0] IMEM_NOP       = 8'h00;

endpackage

// File: rtl/instr_mem_loader_ram.sv
// instr_ram: DEPTH x DW instruction storage.
//   clk_50m            : clock
//   we, waddr, wdata   : synchronous write port
//   raddr, rdata       : asynchronous read port (the CPU fetches in the same cycle)
module instr_ram #(
  parameter int DEPTH = 32,
  parameter int AW    = 5,
  parameter int DW    = 8
) (
  input  logic          clk_50m,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] rdata
);

  logic [DW-1:0] mem [DEPTH];

  always_ff @(posedge clk_50m) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/instr_mem_loader.sv
// instr_mem_loader: writable instruction memory sitting in front of the CPU.
// After reset (or a reload request) the memory is zeroed one word per cycle,
// optionally refilled from a byte stream, and then released to the CPU.
//   clk_50m, reset         : clock, synchronous active-high reset
//   pc / instr             : CPU fetch address / instruction (combinational)
//   cpu_hold               : keep the CPU in reset while high
//   load_start             : request a reload (honoured only in RUN)
//   load_valid/data/last   : byte stream from the host, load_ready = accept
//   load_count             : bytes accepted in the current or last load
//   load_done              : one-cycle pulse on the first RUN cycle after a load
//   err_trunc              : last load filled memory without seeing load_last
module instr_mem_loader
  import imem_pkg::*;
#(
  parameter int DEPTH = IMEM_DEPTH_DEF,
  parameter int AW    = 5,
  parameter int DW    = 8
) (
  input  logic          clk_50m,
  input  logic          reset,
  input  logic [7:0]    pc,
  output logic [DW-1:0] instr,
  output logic          cpu_hold,
  input  logic          load_start,
  input  logic          load_valid,
  input  logic [DW-1:0] load_data,
  input  logic          load_last,
  output logic          load_ready,
  output logic [AW:0]   load_count,
  output logic          load_done,
  output logic          err_trunc
);

  localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);
  localparam logic [DW-1:0] NOP_WORD  = DW'(IMEM_NOP);

  imem_state_t   state_reg;
  logic [AW-1:0] clr_addr_reg;
  logic [AW-1:0] wr_addr_reg;
  logic          next_load_reg;
  logic [AW:0]   load_count_reg;
  logic          load_done_reg;
  logic          err_trunc_reg;
  logic          cpu_hold_reg;
  logic          load_ready_reg;

  logic          ram_we;
  logic [AW-1:0] ram_waddr;
  logic [DW-1:0] ram_wdata;
  logic [DW-1:0] ram_rdata;
  logic          pc_in_range;

  // Exit fires on the write to LAST_ADDR, so the address counters only wrap
  // at the moment the state is left, which leaves them at 0 for next time.
  always_ff @(posedge clk_50m) begin
    if (reset) begin
      state_reg      <= CLEAR;
      clr_addr_reg   <= '0;
      wr_addr_reg    <= '0;
      next_load_reg  <= 1'b0;
      load_count_reg <= '0;
      load_done_reg  <= 1'b0;
      err_trunc_reg  <= 1'b0;
      cpu_hold_reg   <= 1'b1;
      load_ready_reg <= 1'b0;
    end else begin
      load_done_reg <= 1'b0;
      case (state_reg)
        CLEAR: begin
          clr_addr_reg <= clr_addr_reg + 1'b1;
          if (clr_addr_reg == LAST_ADDR) begin
            if (next_load_reg) begin
              state_reg      <= LOAD;
              load_ready_reg <= 1'b1;
            end else begin
              state_reg    <= RUN;
              cpu_hold_reg <= 1'b0;
            end
          end
        end
        LOAD: begin
          if (load_valid) begin
            wr_addr_reg    <= wr_addr_reg + 1'b1;
            load_count_reg <= load_count_reg + 1'b1;
            if (load_last || (wr_addr_reg == LAST_ADDR)) begin
              state_reg      <= RUN;
              load_done_reg  <= 1'b1;
              cpu_hold_reg   <= 1'b0;
              load_ready_reg <= 1'b0;
              if (!load_last) begin
                err_trunc_reg <= 1'b1;
              end
            end
          end
        end
        RUN: begin
          if (load_start) begin
            state_reg      <= CLEAR;
            next_load_reg  <= 1'b1;
            load_count_reg <= '0;
            err_trunc_reg  <= 1'b0;
            wr_addr_reg    <= '0;
            cpu_hold_reg   <= 1'b1;
          end
        end
        default: begin
          state_reg      <= CLEAR;
          cpu_hold_reg   <= 1'b1;
          load_ready_reg <= 1'b0;
        end
      endcase
    end
  end

  // Write-port steering: CLEAR zeroes, LOAD takes the stream. Gated by reset
  // so a byte presented on the reset edge of an aborted load is dropped.
  always_comb begin
    ram_we    = 1'b0;
    ram_waddr = clr_addr_reg;
    ram_wdata = NOP_WORD;
    if (!reset) begin
      case (state_reg)
        CLEAR: ram_we = 1'b1;
        LOAD: begin
          ram_we    = load_valid;
          ram_waddr = wr_addr_reg;
          ram_wdata = load_data;
        end
        default: ram_we = 1'b0;
      endcase
    end
  end

  instr_ram #(
    .DEPTH (DEPTH),
    .AW    (AW),
    .DW    (DW)
  ) u_ram (
    .clk_50m (clk_50m),
    .we      (ram_we),
    .waddr   (ram_waddr),
    .wdata   (ram_wdata),
    .raddr   (pc[AW-1:0]),
    .rdata   (ram_rdata)
  );

  // Fetches beyond the array must not alias onto low addresses.
  assign pc_in_range = ({1'b0, pc} < 9'(DEPTH));

  assign instr      = ((state_reg == RUN) && pc_in_range) ? ram_rdata : NOP_WORD;
  assign cpu_hold   = cpu_hold_reg;
  assign load_ready = load_ready_reg;
  assign load_count = load_count_reg;
  assign load_done  = load_done_reg;
  assign err_trunc  = err_trunc_reg;

endmodule

// File: tb/tb_instr_mem_loader.sv
module tb_instr_mem_loader;

  localparam int DEPTH = 32;
  localparam int AW    = 5;
  localparam int DW    = 8;

  logic          clk_50m = 1'b0;
  logic          reset;
  logic [7:0]    pc;
  logic [DW-1:0] instr;
  logic          cpu_hold;
  logic          load_start;
  logic          load_valid;
  logic [DW-1:0] load_data;
  logic          load_last;
  logic          load_ready;
  logic [AW:0]   load_count;
  logic          load_done;
  logic          err_trunc;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic [7:0]    pc;
    logic [DW-1:0] exp;
  } rd_vec_t;

  rd_vec_t rv [10];

  always #10 clk_50m = ~clk_50m;

  instr_mem_loader #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) dut (
    .clk_50m    (clk_50m),
    .reset      (reset),
    .pc         (pc),
    .instr      (instr),
    .cpu_hold   (cpu_hold),
    .load_start (load_start),
    .load_valid (load_valid),
    .load_data  (load_data),
    .load_last  (load_last),
    .load_ready (load_ready),
    .load_count (load_count),
    .load_done  (load_done),
    .err_trunc  (err_trunc)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_50m);
    #1;
  endtask

  task automatic send(input logic [7:0] d, input logic last);
    load_valid = 1'b1;
    load_data  = d;
    load_last  = last;
    tick();
    load_valid = 1'b0;
    load_last  = 1'b0;
  endtask

  // Pulse load_start, then count cycles (from the pulse cycle) until load_ready.
  task automatic start_and_wait(output int n);
    load_start = 1'b1;
    tick();
    load_start = 1'b0;
    n = 1;
    while (!load_ready && n < 200) begin
      tick();
      n++;
    end
  endtask

  // Count locations that read back non-zero.
  task automatic count_nonzero(output int bad);
    bad = 0;
    for (int i = 0; i < DEPTH; i++) begin
      pc = 8'(i);
      #1;
      if (instr !== 8'h00) bad++;
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] prog1 [5];
    logic [7:0] stall_bytes [3];
    logic       stall_valid [7];
    int n, dones, readys, bad, k;

    prog1       = '{8'h49, 8'hC1, 8'h18, 8'hA9, 8'h4D};
    stall_bytes = '{8'h5A, 8'hA5, 8'h3C};
    stall_valid = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};

    reset = 1'b1; pc = 8'h00; load_start = 1'b0;
    load_valid = 1'b0; load_data = 8'h00; load_last = 1'b0;

    // ---------------- reset and idle ----------------
    tick();
    tick();
    check("rst_cpu_hold", cpu_hold, 1);
    check("rst_load_ready", load_ready, 0);
    check("rst_load_done", load_done, 0);
    check("rst_err_trunc", err_trunc, 0);
    check("rst_load_count", load_count, 0);
    check("rst_instr", instr, 8'h00);
    reset = 1'b0;
    dones = 0;
    for (int cyc = 1; cyc <= 40; cyc++) begin
      check($sformatf("idle_hold_c%0d", cyc), cpu_hold, (cyc <= 32) ? 1 : 0);
      if (load_done) dones++;
      tick();
    end
    check("idle_no_done", dones, 0);
    count_nonzero(bad);
    check("idle_mem_zero", bad, 0);
    $display("idle: cpu_hold released after 32 clear cycles");

    // ---------------- 5-byte program ----------------
    start_and_wait(n);
    check("ready_latency", n, 33);
    for (int i = 0; i < 5; i++) begin
      send(prog1[i], i == 4);
      $display("load byte %0d = 0x%02h", i, prog1[i]);
    end
    check("p1_done", load_done, 1);
    check("p1_hold", cpu_hold, 0);
    check("p1_count", load_count, 5);
    check("p1_err", err_trunc, 0);
    tick();
    check("p1_done_pulse_end", load_done, 0);

    rv[0] = '{8'd0,  8'h49};
    rv[1] = '{8'd1,  8'hC1};
    rv[2] = '{8'd2,  8'h18};
    rv[3] = '{8'd3,  8'hA9};
    rv[4] = '{8'd4,  8'h4D};
    rv[5] = '{8'd5,  8'h00};
    rv[6] = '{8'd31, 8'h00};
    rv[7] = '{8'd32, 8'h00};
    rv[8] = '{8'h40, 8'h00};
    rv[9] = '{8'hFF, 8'h00};
    for (int i = 0; i < 10; i++) begin
      pc = rv[i].pc;
      #1;
      check($sformatf("p1_read_pc%0d", rv[i].pc), instr, rv[i].exp);
      $display("read pc=0x%02h instr=0x%02h", pc, instr);
    end

    // ---------------- 32 bytes, no load_last ----------------
    start_and_wait(n);
    check("full_ready_latency", n, 33);
    readys = 0;
    for (int i = 0; i < 32; i++) begin
      if (load_ready) readys++;
      send(8'(i + 1), 1'b0);
    end
    check("full_ready_held", readys, 32);
    check("full_done", load_done, 1);
    check("full_err", err_trunc, 1);
    check("full_count", load_count, 32);
    check("full_hold", cpu_hold, 0);
    pc = 8'd31; #1;
    check("full_read_pc31", instr, 8'h20);
    pc = 8'd0; #1;
    check("full_read_pc0", instr, 8'h01);
    $display("full load: count=%0d err_trunc=%0d", load_count, err_trunc);

    // ---------------- stalled sender + ignored load_start ----------------
    start_and_wait(n);
    check("stall_ready_latency", n, 33);
    check("restart_clears_err", err_trunc, 0);
    check("restart_clears_count", load_count, 0);
    k = 0;
    for (int s = 0; s < 7; s++) begin
      if (stall_valid[s]) begin
        send(stall_bytes[k], k == 2);
        k++;
        check($sformatf("stall_count_s%0d", s), load_count, k);
      end else begin
        load_valid = 1'b0;
        load_data  = 8'hFF;
        load_start = (s == 2);
        tick();
        load_start = 1'b0;
        check($sformatf("stall_hold_count_s%0d", s), load_count, k);
        check($sformatf("stall_ready_s%0d", s), load_ready, 1);
      end
      $display("stall step %0d valid=%0d count=%0d", s, stall_valid[s], load_count);
    end
    check("stall_done", load_done, 1);
    for (int i = 0; i < 3; i++) begin
      pc = 8'(i); #1;
      check($sformatf("stall_read_pc%0d", i), instr, stall_bytes[i]);
    end
    pc = 8'd3; #1;
    check("stall_read_pc3_cleared", instr, 8'h00);
    pc = 8'h40; #1;
    check("pc_out_of_range", instr, 8'h00);

    // ---------------- reset mid-load ----------------
    start_and_wait(n);
    send(8'h11, 1'b0);
    send(8'h22, 1'b0);
    check("abort_count_before", load_count, 2);
    reset      = 1'b1;
    load_valid = 1'b1;
    load_data  = 8'hEE;
    tick();
    reset = 1'b0;
    n = 1; dones = 0; readys = 0;
    while (cpu_hold && n < 100) begin
      if (load_done) dones++;
      if (load_ready) readys++;
      tick();
      n++;
    end
    load_valid = 1'b0;
    check("abort_release_cycle", n, 33);
    check("abort_no_done", dones + (load_done ? 1 : 0), 0);
    check("abort_no_ready", readys, 0);
    check("abort_count", load_count, 0);
    count_nonzero(bad);
    check("abort_mem_zero", bad, 0);
    $display("abort: released after %0d cycles, nonzero locations=%0d", n, bad);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/instr_mem_loader.md
# instr_mem_loader

Writable instruction memory with a byte-stream load port, replacing the fixed instruction ROM that feeds `instr` to `Microprocessor`. It sits directly upstream of the processor. It returns `instr` combinationally from the processor's `pc`, and holds the processor (`cpu_hold`) while the memory is cleared or being loaded. A host (switch/UART front end) can then reprogram the CPU on the FPGA board without resynthesis.

## Interface
- `DEPTH`, 32: number of instruction bytes; must be a power of 2, at most 256.
- `AW`, 5: address width, equal to log2(DEPTH).
- `DW`, 8: instruction width.

- `clk_50m`  in  1: system clock. One clock domain.
- `reset`  in  1: synchronous, active-high reset.
- `pc`  in  8: fetch address from the processor.
- `instr`  out  DW: instruction at `pc` (combinational).
- `cpu_hold`  out  1: high means the processor must be held in reset.
- `load_start`  in  1: single-cycle request to begin a reload.
- `load_valid`  in  1: byte valid.
- `load_data`  in  DW: byte to write.
- `load_last`  in  1: marks the final byte of a program; qualified by `load_valid`.
- `load_ready`  out  1: loader accepts a byte this cycle.
- `load_count`  out  AW+1: bytes accepted in the current or last load.
- `load_done`  out  1: one-cycle pulse when a load completes.
- `err_trunc`  out  1: sticky flag; the last load hit DEPTH without `load_last`.

## Operation
- FSM states: CLEAR, LOAD, RUN.
- Reset enters CLEAR with `clr_addr`=0 and `next_load`=0.
- Reset values of outputs: `cpu_hold`=1, `load_ready`=0, `load_done`=0, `err_trunc`=0, `load_count`=0, `instr`=0x00.
- **CLEAR**
  - Writes 0x00 to `mem[clr_addr]` and increments `clr_addr`, one location per cycle.
  - After the write to location DEPTH-1, go to LOAD if `next_load`=1, otherwise go to RUN.
  - `load_ready`=0 throughout.
- **LOAD**
  - `load_ready`=1.
  - A transfer occurs when `load_valid` and `load_ready` are both high. It writes `load_data` to `mem[wr_addr]` and increments both `wr_addr` and `load_count`.
  - Go to RUN when the transferred byte has `load_last`=1, or when the transfer wrote address DEPTH-1.
  - If the write to DEPTH-1 occurs without `load_last`, set `err_trunc`.
  - On the exit transfer, `load_done` pulses in the next cycle, coinciding with the first RUN cycle.
- **RUN**
  - `cpu_hold`=0 and `load_ready`=0.
  - `instr` = `mem[pc[AW-1:0]]` when `pc < DEPTH`; otherwise `instr` = 0x00.
  - On `load_start`: set `next_load`=1, clear `load_count`, `err_trunc` and `wr_addr`, then go to CLEAR.
- Outside RUN, `instr` is forced to 0x00 and `cpu_hold`=1.
- `load_start` is ignored in CLEAR and LOAD.
- `load_valid` is ignored outside LOAD. No byte is written and `load_count` does not change.
- A zero-length program cannot be expressed: `load_last` must accompany a byte.
- Reset mid-load aborts the load:
  - The FSM goes to CLEAR, so memory ends all-zero.
  - `load_done` does not pulse.
  - `next_load`=0, so the FSM then goes to RUN.
- Arithmetic:
  - `wr_addr` and `clr_addr` are AW bits and never wrap within a state; the exit condition fires first.
  - `load_count` saturates naturally at DEPTH.

## Timing
- After reset deasserts, CLEAR lasts exactly DEPTH cycles. `cpu_hold` falls in cycle DEPTH+1.
- From the `load_start` cycle to `load_ready`=1 is DEPTH+1 cycles.
- Write latency is 1: a byte accepted at edge N is readable on `instr` after edge N.
- Read latency is 0: `instr` follows `pc` combinationally within the same cycle.
- Loading N bytes with `load_valid` held high takes N cycles. `load_done` and `cpu_hold`=0 occur in the cycle after the last transfer.
- Backpressure: `load_ready` never deasserts mid-LOAD. The sender may stall with `load_valid`=0 indefinitely.

## Structure
- Package `imem_pkg`:
  - State enum `imem_state_t` (CLEAR, LOAD, RUN).
  - `IMEM_DEPTH_DEF`=32.
  - `IMEM_NOP`=8'h00.
- Sub-module `instr_ram`:
  - DEPTH×DW array.
  - One synchronous write port (`we`, `waddr`, `wdata`).
  - One asynchronous read port (`raddr`, `rdata`).
- Top-level FSM, counters and output muxing live in `instr_mem_loader`.
- The board top instantiates `instr_mem_loader` and drives `Microprocessor.reset` with `reset | cpu_hold`.

## Test plan
- Reset, then idle for 40 cycles: `cpu_hold`=1 for cycles 1–32 and 0 from cycle 33. `instr`=0x00 for every `pc` in 0..31. `load_done` never pulses.
- `load_start`, then stream 0x49, 0xC1, 0x18, 0xA9, 0x4D with `load_last` on 0x4D:
  - `load_ready` rises 33 cycles after `load_start`.
  - `load_count`=5, a single `load_done` pulse, `err_trunc`=0.
  - With `pc`=0..4 the read returns those bytes; `pc`=5..31 returns 0x00.
- Load 32 bytes 0x01..0x20 with no `load_last`: exit after byte 32, `err_trunc`=1, `load_count`=32, `pc`=31 reads 0x20. A following `load_start` clears `err_trunc`.
- Stalled sender (`load_valid` toggling 1,0,0,1,…) for 3 bytes: only valid cycles write. `load_count` steps 1→2→3. Bytes land at addresses 0..2.
- Assert `reset` after 2 of 4 bytes have been loaded: CLEAR then RUN, all locations 0x00, no `load_done`. `load_valid` during CLEAR writes nothing.
- Drive `pc`=0x40 in RUN: `instr`=0x00. `load_start` pulsed during LOAD is ignored and `load_count` is unaffected.
